// File: rtl/me_search_if.sv
// Control/result bundle between the motion-estimation search sequencer and its datapath.
// Optional ME_EARLY_TERM_EN adds the early-termination threshold.
interface me_search_if #(
  parameter int SAD_BIT_WIDTH = 14,
  parameter int COL_AW        = 5
);
  logic                     start_i;
  logic                     busy_o;
  logic                     cur_load_o;
  logic                     fifo_flush_o;
  logic                     ref_rd_en_o;
  logic [COL_AW-1:0]        ref_col_addr_o;
  logic [SAD_BIT_WIDTH-1:0] msad_i;
  logic [3:0]               msad_index_i;
  logic [SAD_BIT_WIDTH-1:0] best_sad_o;
  logic [COL_AW-1:0]        best_mv_x_o;
  logic [3:0]               best_mv_y_o;
  logic                     done_o;
`ifdef ME_EARLY_TERM_EN
  logic [SAD_BIT_WIDTH-1:0] early_thr_i;
`endif

  // The sequencer drives control and results; the datapath/environment drives the rest.
  modport master (
    input  start_i, msad_i, msad_index_i,
`ifdef ME_EARLY_TERM_EN
    input  early_thr_i,
`endif
    output busy_o, cur_load_o, fifo_flush_o, ref_rd_en_o, ref_col_addr_o,
    output best_sad_o, best_mv_x_o, best_mv_y_o, done_o
  );

  modport slave (
    output start_i, msad_i, msad_index_i,
`ifdef ME_EARLY_TERM_EN
    output early_thr_i,
`endif
    input  busy_o, cur_load_o, fifo_flush_o, ref_rd_en_o, ref_col_addr_o,
    input  best_sad_o, best_mv_x_o, best_mv_y_o, done_o
  );
endinterface

// File: rtl/me_search_ctrl.sv
// Sequencer for one motion-estimation block search: load, flush, stream columns, track best SAD.
// Define ME_EARLY_TERM_EN to stop streaming once a batch minimum is at or below early_thr_i.
module me_search_ctrl #(
  parameter int EDGE_LEN        = 8,
  parameter int PIXELS_IN_BATCH = 16,
  parameter int SAD_BIT_WIDTH   = 14,
  parameter int NUM_COLS        = 23,
  parameter int PIPE_LAT        = 3,
  parameter int COL_AW          = 5
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  me_search_if.master bus
);

  localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [COL_AW-1:0]  FIRST_BATCH_COL = COL_AW'(EDGE_LEN - 1);
  localparam logic [COL_AW-1:0]  LAST_COL        = COL_AW'(NUM_COLS - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN      = DRAIN_W'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [PIPE_LAT-1:0] tap_vld;
  logic [COL_AW-1:0]  tap_k [PIPE_LAT];

  logic              launch;
  logic [COL_AW-1:0] launch_k;
  logic              tap_hit;
  logic              better;
  logic              early_stop;

  // A column completes a batch once the array holds EDGE_LEN columns.
  assign launch   = bus.ref_rd_en_o && (bus.ref_col_addr_o >= FIRST_BATCH_COL);
  assign launch_k = bus.ref_col_addr_o - FIRST_BATCH_COL;
  assign tap_hit  = tap_vld[PIPE_LAT-1];
  // Strict compare so ties keep the earlier batch.
  assign better   = tap_hit && (bus.msad_i < bus.best_sad_o);

`ifdef ME_EARLY_TERM_EN
  assign early_stop = tap_hit && (bus.msad_i <= bus.early_thr_i);
`else
  assign early_stop = 1'b0;
`endif

  // NOTE: the batch-index pipe carries data qualified by tap_vld, so it needs no reset.
  always_ff @(posedge clk_i) begin
    tap_k[0] <= launch_k;
    for (int i = 1; i < PIPE_LAT; i++) tap_k[i] <= tap_k[i-1];
  end

  // NOTE: non-blocking assignments so every register samples its pre-edge value.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state              <= S_IDLE;
      drain_cnt          <= '0;
      tap_vld            <= '0;
      bus.busy_o         <= 1'b0;
      bus.cur_load_o     <= 1'b0;
      bus.fifo_flush_o   <= 1'b0;
      bus.ref_rd_en_o    <= 1'b0;
      bus.ref_col_addr_o <= '0;
      bus.best_sad_o     <= '0;
      bus.best_mv_x_o    <= '0;
      bus.best_mv_y_o    <= '0;
      bus.done_o         <= 1'b0;
    end else begin
      bus.cur_load_o   <= 1'b0;
      bus.fifo_flush_o <= 1'b0;
      bus.done_o       <= 1'b0;
      tap_vld          <= PIPE_LAT'({tap_vld, launch});

      if (better) begin
        bus.best_sad_o  <= bus.msad_i;
        bus.best_mv_x_o <= tap_k[PIPE_LAT-1];
        bus.best_mv_y_o <= bus.msad_index_i;
      end

      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            state            <= S_LOAD;
            bus.busy_o       <= 1'b1;
            bus.cur_load_o   <= 1'b1;
            bus.fifo_flush_o <= 1'b1;
            bus.best_sad_o   <= '1;
            bus.best_mv_x_o  <= '0;
            bus.best_mv_y_o  <= '0;
            tap_vld          <= '0;
          end
        end
        S_LOAD: begin
          state              <= S_STREAM;
          bus.ref_rd_en_o    <= 1'b1;
          bus.ref_col_addr_o <= '0;
        end
        S_STREAM: begin
          if (bus.ref_col_addr_o == LAST_COL || early_stop) begin
            state              <= S_DRAIN;
            bus.ref_rd_en_o    <= 1'b0;
            bus.ref_col_addr_o <= '0;
            drain_cnt          <= '0;
          end else begin
            bus.ref_col_addr_o <= bus.ref_col_addr_o + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
            state      <= S_DONE;
            bus.done_o <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          bus.busy_o <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
